// File: rtl/maxt_pkg.sv
// Shared constants and types for the max-of-t histogram readout framer.
package maxt_pkg;

    localparam int unsigned NBINS         = 32;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned CNT_W         = 64;
    localparam int unsigned FRAME_WORDS   = 68;
    localparam int unsigned IDX_W         = 7;
    localparam int unsigned BIN_IDX_W     = 5;
    localparam int unsigned SEQ_W         = 8;
    localparam int unsigned T_WEIGHT_LOG2 = 4;

    localparam logic [15:0] MAGIC = 16'h4D54;

    localparam logic [IDX_W-1:0] IDX_HDR    = 7'd0;
    localparam logic [IDX_W-1:0] IDX_TOT_HI = 7'd1;
    localparam logic [IDX_W-1:0] IDX_TOT_LO = 7'd2;
    localparam logic [IDX_W-1:0] IDX_BIN0   = 7'd3;
    localparam logic [IDX_W-1:0] IDX_CSUM   = 7'(FRAME_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [CNT_W-1:0] bin_arr_t [NBINS-1:0];

endpackage

// File: rtl/maxt_readout.sv
// Snapshots the histogram on start and streams it as a 68-word frame
// (header, total, 32 bins, XOR checksum) over a valid/ready port.
module maxt_readout
    import maxt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  bin_arr_t          hist_bins,
    input  logic [CNT_W-1:0]  hist_total,
    input  logic              start,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              sum_mismatch
);

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_idx, w_idx_nxt, w_sel_idx;
    logic [WORD_W-1:0]      r_data, w_data_nxt, w_word;
    logic [WORD_W-1:0]      r_csum, w_csum_nxt;
    logic [CNT_W-1:0]       r_binsum, w_binsum_nxt;
    logic [CNT_W-1:0]       r_total;
    logic [SEQ_W-1:0]       r_seq, w_seq_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_last, w_last_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_mis, w_mis_nxt;
    logic                   w_load, w_xfer;
    logic [BIN_IDX_W-1:0]   w_sel_bin, w_cur_bin;
    logic [CNT_W-1:0]       w_sel_cnt;
    bin_arr_t               r_bins;

    assign w_xfer    = r_valid & m_ready;
    // Word being loaded into the output register: header on start, else the next index.
    assign w_sel_idx = (r_state == IDLE) ? IDX_HDR : r_idx + 7'd1;
    assign w_sel_bin = BIN_IDX_W'((w_sel_idx - IDX_BIN0) >> 1);
    assign w_cur_bin = BIN_IDX_W'((r_idx - IDX_BIN0) >> 1);
    assign w_sel_cnt = r_bins[w_sel_bin];

    // Frame word mux; the checksum folds in the word currently on the bus.
    always_comb begin
        w_word = '0;
        case (w_sel_idx)
            IDX_HDR:    w_word = {MAGIC, 8'(NBINS), r_seq};
            IDX_TOT_HI: w_word = r_total[63:32];
            IDX_TOT_LO: w_word = r_total[31:0];
            IDX_CSUM:   w_word = r_csum ^ r_data;
            default:    w_word = w_sel_idx[0] ? w_sel_cnt[63:32] : w_sel_cnt[31:0];
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;
        w_last_nxt   = r_last;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_mis_nxt    = r_mis;
        w_csum_nxt   = r_csum;
        w_binsum_nxt = r_binsum;
        w_seq_nxt    = r_seq;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_nxt  = SEND;
                    w_idx_nxt    = IDX_HDR;
                    w_data_nxt   = w_word;
                    w_valid_nxt  = 1'b1;
                    w_last_nxt   = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_mis_nxt    = 1'b0;
                    w_csum_nxt   = '0;
                    w_binsum_nxt = '0;
                end
            end
            SEND: begin
                if (w_xfer) begin
                    if (r_idx == IDX_CSUM) begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_mis_nxt   = (r_binsum << T_WEIGHT_LOG2) != r_total;
                        w_seq_nxt   = r_seq + 8'd1;
                    end else begin
                        w_idx_nxt  = w_sel_idx;
                        w_data_nxt = w_word;
                        w_last_nxt = (w_sel_idx == IDX_CSUM);
                        w_csum_nxt = r_csum ^ r_data;
                        // Low half of a bin completes it; add the whole 64-bit count once.
                        if ((r_idx > IDX_BIN0) && !r_idx[0]) begin
                            w_binsum_nxt = r_binsum + r_bins[w_cur_bin];
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mis    <= 1'b0;
            r_csum   <= '0;
            r_binsum <= '0;
            r_seq    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_last   <= w_last_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_mis    <= w_mis_nxt;
            r_csum   <= w_csum_nxt;
            r_binsum <= w_binsum_nxt;
            r_seq    <= w_seq_nxt;
        end
    end

    // Snapshot needs no reset; it is only read while a frame is in flight.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_bins  <= hist_bins;
            r_total <= hist_total;
        end
    end

    assign m_data       = r_data;
    assign m_valid      = r_valid;
    assign m_last       = r_last;
    assign busy         = r_busy;
    assign done         = r_done;
    assign sum_mismatch = r_mis;

endmodule

// File: tb/tb_maxt_readout.sv
// Directed bench for maxt_readout: frame layout, checksum, consistency flag,
// back-pressure, snapshot isolation, ignored start and mid-frame reset.
module tb_maxt_readout;
    import maxt_pkg::*;

    localparam int CYC_BUDGET = 1000;

    logic              clk;
    logic              rst;
    bin_arr_t          hist_bins;
    logic [63:0]       hist_total;
    logic              start;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;
    logic              sum_mismatch;

    int                n_cmp;
    int                n_err;
    int                nw;
    bin_arr_t          snap_bins;
    logic [31:0]       got_w [FRAME_WORDS];
    logic              got_l [FRAME_WORDS];
    logic [31:0]       exp_w [FRAME_WORDS];
    logic [3:0]        rdy_pat;

    maxt_readout dut (
        .clk          (clk),
        .rst          (rst),
        .hist_bins    (hist_bins),
        .hist_total   (hist_total),
        .start        (start),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done),
        .sum_mismatch (sum_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Expected frame built from the bench's own copy of the histogram.
    task automatic build_exp(input logic [7:0] seq, input logic [63:0] tot);
        logic [31:0] x;
        exp_w[0] = {16'h4D54, 8'd32, seq};
        exp_w[1] = tot[63:32];
        exp_w[2] = tot[31:0];
        for (int k = 0; k < 32; k++) begin
            exp_w[3 + 2*k] = snap_bins[k][63:32];
            exp_w[4 + 2*k] = snap_bins[k][31:0];
        end
        x = '0;
        for (int i = 0; i < 67; i++) x = x ^ exp_w[i];
        exp_w[67] = x;
    endtask

    task automatic compare_frame(input string tag);
        for (int i = 0; i < FRAME_WORDS; i++) begin
            chk($sformatf("%s_word%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
            chk($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(i == 67));
        end
    endtask

    // Receives words until 68 transfers, a reset injection point, or the budget.
    task automatic collect(input bit stall, input int chg_at, input int start_at,
                           input int rst_at, output int n);
        int          cyc;
        bit          fin;
        logic        pv, pr, pl;
        logic [31:0] pd;
        n = 0; cyc = 0; fin = 1'b0;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        while (!fin && cyc < CYC_BUDGET) begin
            @(negedge clk);
            if (n == rst_at) begin
                rst = 1'b1;
                fin = 1'b1;
            end else begin
                if (n == chg_at) begin
                    for (int k = 0; k < 32; k++) hist_bins[k] = {32'hDEADBEEF, 32'(k)};
                end
                start   = (start_at >= 0) && (n == start_at);
                m_ready = stall ? rdy_pat[cyc % 4] : 1'b1;
                chk("valid_in_frame", 64'(m_valid), 64'd1);
                chk("no_done_in_frame", 64'(done), 64'd0);
                if (start_at >= 0) chk("busy_held", 64'(busy), 64'd1);
                if (pv && !pr) begin
                    chk("stall_data", 64'(m_data), 64'(pd));
                    chk("stall_last", 64'(m_last), 64'(pl));
                end
                pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
                if (m_valid && m_ready) begin
                    got_w[n] = m_data;
                    got_l[n] = m_last;
                    n++;
                    if (n == FRAME_WORDS) fin = 1'b1;
                end
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) chk("collect_timeout", 64'd0, 64'd1);
    endtask

    // Checks the done cycle; optionally issues a back-to-back start in it.
    task automatic finish_frame(input logic exp_mis, input bit restart);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_clear", 64'(busy), 64'd0);
        chk("valid_clear", 64'(m_valid), 64'd0);
        chk("last_clear", 64'(m_last), 64'd0);
        chk("sum_mismatch", 64'(sum_mismatch), 64'(exp_mis));
        if (restart) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end else begin
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("idle_no_valid", 64'(m_valid), 64'd0);
            chk("sum_mismatch_hold", 64'(sum_mismatch), 64'(exp_mis));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rdy_pat = 4'b1001;
        rst = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        hist_total = '0;
        for (int k = 0; k < 32; k++) hist_bins[k] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum_mismatch", 64'(sum_mismatch), 64'd0);
        rst = 1'b0;

        // All-zero histogram still sends the full frame.
        snap_bins = hist_bins;
        do_start();
        collect(1'b0, -1, -1, -1, nw);
        chk("t1_nwords", 64'(nw), 64'd68);
        build_exp(8'd0, 64'd0);
        compare_frame("t1");
        chk("t1_hdr", 64'(got_w[0]), 64'h4D542000);
        chk("t1_csum", 64'(got_w[67]), 64'h4D542000);
        finish_frame(1'b0, 1'b0);

        // Bins k+1, consistent total; second frame carries seq 1.
        for (int k = 0; k < 32; k++) hist_bins[k] = 64'(k + 1);
        hist_total = 64'd8448;
        snap_bins = hist_bins;
        do_start();
        collect(1'b0, -1, -1, -1, nw);
        chk("t2_nwords", 64'(nw), 64'd68);
        build_exp(8'd1, 64'd8448);
        compare_frame("t2");
        chk("t2_hdr", 64'(got_w[0]), 64'h4D542001);
        chk("t2_tot_lo", 64'(got_w[2]), 64'd8448);
        chk("t2_csum", 64'(got_w[67]), 64'h4D540121);
        finish_frame(1'b0, 1'b0);

        // Total off by one: flag set; next frame started in the done cycle.
        hist_total = 64'd8449;
        do_start();
        collect(1'b0, -1, -1, -1, nw);
        chk("t3_nwords", 64'(nw), 64'd68);
        build_exp(8'd2, 64'd8449);
        compare_frame("t3");
        chk("t3_csum", 64'(got_w[67]), 64'h4D540123);
        for (int k = 0; k < 32; k++) hist_bins[k] = '0;
        hist_bins[5] = 64'h0000_0001_FFFF_FFFF;
        hist_total = 64'h0000_001F_FFFF_FFF0;
        finish_frame(1'b1, 1'b1);

        // Back-pressure 1,0,0,1 with no gap after the previous done.
        snap_bins = hist_bins;
        collect(1'b1, -1, -1, -1, nw);
        chk("t4_nwords", 64'(nw), 64'd68);
        build_exp(8'd3, 64'h0000_001F_FFFF_FFF0);
        compare_frame("t4");
        chk("t4_w13", 64'(got_w[13]), 64'h1);
        chk("t4_w14", 64'(got_w[14]), 64'hFFFF_FFFF);
        finish_frame(1'b0, 1'b0);

        // Inputs change after acceptance; start at idx 10 must be ignored.
        for (int k = 0; k < 32; k++) hist_bins[k] = 64'(k) * 64'h0000_0001_0000_0003 + 64'd7;
        hist_total = 64'h0000_1F00_0000_6B00;
        snap_bins = hist_bins;
        do_start();
        collect(1'b0, 1, 10, -1, nw);
        chk("t5_nwords", 64'(nw), 64'd68);
        build_exp(8'd4, 64'h0000_1F00_0000_6B00);
        compare_frame("t5");
        finish_frame(1'b0, 1'b0);

        // Reset at idx 30 aborts the frame and clears seq.
        for (int k = 0; k < 32; k++) hist_bins[k] = '0;
        hist_total = '0;
        do_start();
        collect(1'b0, -1, -1, 30, nw);
        chk("t6_abort_at", 64'(nw), 64'd30);
        @(negedge clk);
        chk("t6_valid_off", 64'(m_valid), 64'd0);
        chk("t6_busy_off", 64'(busy), 64'd0);
        chk("t6_no_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_idle_done", 64'(done), 64'd0);
            chk("t6_idle_valid", 64'(m_valid), 64'd0);
        end
        for (int k = 0; k < 32; k++) hist_bins[k] = 64'(k + 1);
        hist_total = 64'd8448;
        snap_bins = hist_bins;
        do_start();
        collect(1'b0, -1, -1, -1, nw);
        chk("t6_nwords", 64'(nw), 64'd68);
        build_exp(8'd0, 64'd8448);
        compare_frame("t6");
        chk("t6_hdr", 64'(got_w[0]), 64'h4D542000);
        chk("t6_csum", 64'(got_w[67]), 64'h4D540120);
        finish_frame(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
